tx_channel_arbiter: RTL

TX_CHANNEL_ARBITER -- requirements
Module: tx_channel_arbiter

---
 rtl/tx_channel_arbiter_if.sv | 22 ++
 rtl/tx_channel_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/tx_channel_arbiter_if.sv
// Signal bundle between tx_channel_arbiter, its four channel FIFOs and the shared UART.
// The master modport is the arbiter side; the slave modport is the FIFO/UART side.
interface tx_channel_arbiter_if;
  logic [3:0]  full;
  logic [31:0] chData;
  logic        txBusy;
  logic [3:0]  oRdclk;
  logic        oNewData;
  logic [7:0]  oData;
  logic [1:0]  oChannel;
  logic        oBusy;

  modport master (
    input  full, chData, txBusy,
    output oRdclk, oNewData, oData, oChannel, oBusy
  );

  modport slave (
    output full, chData, txBusy,
    input  oRdclk, oNewData, oData, oChannel, oBusy
  );
endinterface

// File: rtl/tx_channel_arbiter.sv
// Round-robin arbiter that drains BURST_LEN bytes per grant from one of four FIFOs into one UART.
// Define TX_CH_HEADER_EN to precede every burst with a 0xA0|channel header byte.
module tx_channel_arbiter #(
  parameter int BURST_LEN = 32,
  parameter int NCH       = 4
) (
  input logic                  clk,
  input logic                  rst,
  tx_channel_arbiter_if.master bus
);
  localparam logic [5:0] CNT_LAST = 6'(BURST_LEN - 1);

  typedef enum logic [2:0] {IDLE, HDR, RD, WT, LAT, SEND, GUARD, DRAIN} state_t;

  state_t     r_state;
  logic [1:0] r_last;
  logic [1:0] r_chan;
  logic [5:0] r_cnt;
  logic [3:0] r_rdclk;
  logic       r_new;
  logic [7:0] r_data;

  logic [1:0] w_grant;
  logic       w_any;
  logic [7:0] w_ch_byte;
  logic       w_hdr_pend;

  // Scan from the channel after the last grant; the closest requester wins.
  always_comb begin
    // NOTE: default first, so no path leaves w_grant unassigned and no latch is inferred.
    w_grant = r_last;
    for (int i = NCH; i >= 1; i--) begin
      if (bus.full[r_last + 2'(i)]) w_grant = r_last + 2'(i);
    end
  end

  assign w_any     = |bus.full;
  assign w_ch_byte = bus.chData[{r_chan, 3'b000} +: 8];

`ifdef TX_CH_HEADER_EN
  logic r_hdr;

  // Marks that the current DRAIN wait belongs to the header byte, so cntB must not advance.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hdr <= 1'b0;
    end else if (r_state == HDR) begin
      r_hdr <= 1'b1;
    end else if (r_state == DRAIN && !bus.txBusy) begin
      r_hdr <= 1'b0;
    end
  end

  assign w_hdr_pend = r_hdr;
`else
  assign w_hdr_pend = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_last  <= 2'd3;
      r_chan  <= 2'd0;
      r_cnt   <= 6'd0;
      r_rdclk <= 4'd0;
      r_new   <= 1'b0;
      r_data  <= 8'h00;
    end else begin
      // NOTE: strobes default low and are raised only by their own state; non-blocking
      // assignments keep every read in this block on the pre-edge value.
      r_rdclk <= 4'd0;
      r_new   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_chan <= w_grant;
            r_last <= w_grant;
            r_cnt  <= 6'd0;
`ifdef TX_CH_HEADER_EN
            r_state <= HDR;
`else
            r_state <= RD;
`endif
          end
        end
`ifdef TX_CH_HEADER_EN
        HDR: begin
          r_data  <= 8'hA0 | {6'd0, r_chan};
          r_new   <= 1'b1;
          r_state <= GUARD;
        end
`endif
        RD: begin
          r_rdclk <= 4'b0001 << r_chan;
          r_state <= WT;
        end
        WT:   r_state <= LAT;
        LAT: begin
          r_data  <= w_ch_byte;
          r_state <= SEND;
        end
        SEND: begin
          r_new   <= 1'b1;
          r_state <= GUARD;
        end
        // The UART raises txBusy one cycle after the strobe; GUARD skips that blind cycle.
        GUARD: r_state <= DRAIN;
        DRAIN: begin
          if (!bus.txBusy) begin
            if (w_hdr_pend) begin
              r_state <= RD;
            end else if (r_cnt == CNT_LAST) begin
              r_state <= IDLE;
            end else begin
              r_cnt   <= r_cnt + 6'd1;
              r_state <= RD;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.oRdclk   = r_rdclk;
  assign bus.oNewData = r_new;
  assign bus.oData    = r_data;
  assign bus.oChannel = r_chan;
  assign bus.oBusy    = (r_state != IDLE);

endmodule
